// File: rtl/spu_ls_pkg.sv
// Shared definitions for the SPU local-store port: read-owner tags,
// arbiter states and the default LS geometry.
package spu_ls_pkg;

  // 256KB local store addressed in 16B quadwords
  localparam int LS_ADDR_W = 14;
  localparam int LS_DATA_W = 128;

  // One instruction line is 64B, i.e. four quadwords
  localparam int IF_LINE_BEATS = 4;
  localparam int IF_LINE_BYTES = IF_LINE_BEATS * 16;

  // Owner tag attached to every read so returned data can be steered
  localparam int TAG_W     = 2;
  localparam int TAG_CODES = 1 << TAG_W;

  typedef enum logic [TAG_W-1:0] {
    TAG_DMA = 2'd0,
    TAG_LSU = 2'd1,
    TAG_IF  = 2'd2
  } ls_tag_e;

  // IDLE arbitrates every cycle; IF_BURST owns the port until the line is issued
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IF_BURST = 1'b1
  } ls_arb_state_e;

endpackage

// File: rtl/ls_rd_tag_pipe.sv
// Delay line that carries {valid, tag, beat} alongside an LS read so the
// owner and beat index emerge in the same cycle as the array's read data.
// A per-tag kill mask wipes matching entries, including the one being
// pushed in the kill cycle.
module ls_rd_tag_pipe
  import spu_ls_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int BEAT_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push_valid,
  input  ls_tag_e              i_push_tag,
  input  logic [BEAT_W-1:0]    i_push_beat,
  input  logic [TAG_CODES-1:0] i_kill,
  output logic                 o_valid,
  output ls_tag_e              o_tag,
  output logic [BEAT_W-1:0]    o_beat
);

  typedef struct packed {
    logic              valid;
    ls_tag_e           tag;
    logic [BEAT_W-1:0] beat;
  } entry_t;

  entry_t r_stage [LAT];
  entry_t w_push;

  // Invalid or killed entries collapse to all-zero so the outputs read as
  // zero whenever nothing is returning.
  function automatic entry_t keepEntry(input entry_t e, input logic [TAG_CODES-1:0] kill);
    entry_t r;
    r = e;
    if (!e.valid || kill[e.tag]) begin
      r = '0;
    end
    return r;
  endfunction

  // Assemble the entry describing this cycle's LS access
  always_comb begin
    w_push       = '0;
    w_push.valid = i_push_valid;
    w_push.tag   = i_push_tag;
    w_push.beat  = i_push_beat;
  end

  // Shift one stage per cycle, filtering every stage through the kill mask
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= keepEntry(w_push, i_kill);
      for (int i = 1; i < LAT; i++) begin
        r_stage[i] <= keepEntry(r_stage[i-1], i_kill);
      end
    end
  end

  assign o_valid = r_stage[LAT-1].valid;
  assign o_tag   = r_stage[LAT-1].tag;
  assign o_beat  = r_stage[LAT-1].beat;

endmodule

// File: rtl/ls_port_arbiter.sv
// Local-store port controller: arbitrates DMA, LSU and IF refill onto the
// single LS quadword port, runs IF refills as uninterruptible line bursts
// (except for branch-redirect flush), and tags returning read data.
module ls_port_arbiter
  import spu_ls_pkg::*;
#(
  parameter int ADDR_W     = LS_ADDR_W,
  parameter int DATA_W     = LS_DATA_W,
  parameter int IF_BEATS   = IF_LINE_BEATS,
  parameter int LS_LAT     = 2,
  parameter int STARVE_MAX = 8,
  localparam int BEAT_W    = $clog2(IF_BEATS),
  localparam int LINE_W    = ADDR_W - BEAT_W,
  localparam int STARVE_W  = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  // DMA requester
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  // Load/store unit requester
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  // Instruction-fetch refill requester
  input  logic              if_req,
  input  logic [LINE_W-1:0] if_line,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_busy,
  output logic              if_done,
  // LS array port
  output logic              ls_en,
  output logic              ls_we,
  output logic [ADDR_W-1:0] ls_addr,
  output logic [DATA_W-1:0] ls_wdata,
  input  logic [DATA_W-1:0] ls_rdata,
  // Tagged read return
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [DATA_W-1:0] rd_data
);

  ls_arb_state_e          r_state;
  logic [LINE_W-1:0]      r_line;
  logic [BEAT_W-1:0]      r_beat;
  logic [STARVE_W-1:0]    r_starve;

  logic                   w_idle;
  logic                   w_burstIssue;
  logic                   w_ifStarved;
  logic                   w_ifWin;
  logic                   w_dmaWin;
  logic                   w_lsuWin;
  logic                   w_lastBeat;
  logic                   w_pushValid;
  ls_tag_e                w_pushTag;
  logic [BEAT_W-1:0]      w_pushBeat;
  logic [TAG_CODES-1:0]   w_kill;
  logic                   w_pipeValid;
  ls_tag_e                w_pipeTag;
  logic [BEAT_W-1:0]      w_pipeBeat;

  // Pick this cycle's winner; reset holds every grant low so the port is quiet
  always_comb begin
    w_idle       = (r_state == ST_IDLE) && !reset;
    w_burstIssue = (r_state == ST_IF_BURST) && !reset;
    w_ifStarved  = (r_starve == STARVE_W'(STARVE_MAX));
    w_lastBeat   = (r_beat == BEAT_W'(IF_BEATS - 1));
    // A redirect never starts a refill in its own cycle, even a starved one
    w_ifWin      = w_idle && if_req && !if_flush && (w_ifStarved || (!dma_req && !lsu_req));
    w_dmaWin     = w_idle && dma_req && !w_ifWin;
    w_lsuWin     = w_idle && lsu_req && !dma_req && !w_ifWin;
  end

  // Drive the LS port from whichever requester owns it this cycle
  always_comb begin
    ls_en    = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    if (w_dmaWin) begin
      ls_en    = 1'b1;
      ls_we    = dma_we;
      ls_addr  = dma_addr;
      ls_wdata = dma_wdata;
    end else if (w_lsuWin) begin
      ls_en    = 1'b1;
      ls_we    = lsu_we;
      ls_addr  = lsu_addr;
      ls_wdata = lsu_wdata;
    end else if (w_ifWin) begin
      ls_en    = 1'b1;
      ls_addr  = {if_line, {BEAT_W{1'b0}}};
    end else if (w_burstIssue) begin
      ls_en    = 1'b1;
      ls_addr  = {r_line, r_beat};
    end
  end

  assign dma_gnt = w_dmaWin;
  assign lsu_gnt = w_lsuWin;
  assign if_gnt  = w_ifWin;
  assign if_busy = w_ifWin || w_burstIssue;

  // Burst sequencer: capture the line on grant, then walk beats 1..last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ifWin) begin
            r_line  <= if_line;
            r_beat  <= BEAT_W'(1);
            r_state <= ST_IF_BURST;
          end
        end
        ST_IF_BURST: begin
          if (if_flush || w_lastBeat) begin
            r_beat  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_beat  <= r_beat + BEAT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Count consecutive cycles where IF asks but is not granted, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!if_req || w_ifWin) begin
      r_starve <= '0;
    end else if (!w_ifStarved) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  // Describe the issued read for the tag pipe and build the flush kill mask
  always_comb begin
    w_pushValid = ls_en && !ls_we;
    w_pushTag   = TAG_IF;
    w_pushBeat  = '0;
    if (w_dmaWin) begin
      w_pushTag = TAG_DMA;
    end else if (w_lsuWin) begin
      w_pushTag = TAG_LSU;
    end
    if (w_burstIssue) begin
      w_pushBeat = r_beat;
    end
    w_kill         = '0;
    w_kill[TAG_IF] = if_flush;
  end

  ls_rd_tag_pipe #(
    .LAT    (LS_LAT),
    .BEAT_W (BEAT_W)
  ) u_tagPipe (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (w_pushValid),
    .i_push_tag   (w_pushTag),
    .i_push_beat  (w_pushBeat),
    .i_kill       (w_kill),
    .o_valid      (w_pipeValid),
    .o_tag        (w_pipeTag),
    .o_beat       (w_pipeBeat)
  );

  // Data is forced to zero when no tagged read is returning
  always_comb begin
    rd_valid = w_pipeValid;
    rd_tag   = w_pipeTag;
    rd_beat  = w_pipeBeat;
    rd_data  = w_pipeValid ? ls_rdata : '0;
    if_done  = w_pipeValid && (w_pipeTag == TAG_IF) && (w_pipeBeat == BEAT_W'(IF_BEATS - 1));
  end

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Testbench for ls_port_arbiter: directed scenarios followed by random
// traffic, with a behavioural model feeding a read-return scoreboard.
module tb_ls_port_arbiter;
  import spu_ls_pkg::*;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 128;
  localparam int IF_BEATS   = 4;
  localparam int LS_LAT     = 2;
  localparam int STARVE_MAX = 8;
  localparam int BEAT_W     = 2;
  localparam int LINE_W     = ADDR_W - BEAT_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dma_req = 1'b0, dma_we = 1'b0, dma_gnt;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic              lsu_req = 1'b0, lsu_we = 1'b0, lsu_gnt;
  logic [ADDR_W-1:0] lsu_addr = '0;
  logic [DATA_W-1:0] lsu_wdata = '0;
  logic              if_req = 1'b0, if_flush = 1'b0, if_gnt, if_busy, if_done;
  logic [LINE_W-1:0] if_line = '0;
  logic              ls_en, ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata = '0;
  logic              rd_valid;
  logic [1:0]        rd_tag;
  logic [BEAT_W-1:0] rd_beat;
  logic [DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  ls_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IF_BEATS(IF_BEATS),
    .LS_LAT(LS_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
    .if_req(if_req), .if_line(if_line), .if_flush(if_flush), .if_gnt(if_gnt), .if_busy(if_busy), .if_done(if_done),
    .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_beat(rd_beat), .rd_data(rd_data)
  );

  typedef struct {
    int                due;
    logic [1:0]        tag;
    logic [BEAT_W-1:0] beat;
    logic [ADDR_W-1:0] addr;
  } rdExp_t;

  rdExp_t            expQ[$];
  logic [ADDR_W-1:0] lsSched [int];
  int                passCount = 0;
  int                checkCount = 0;
  int                cycle = 0;
  bit                monitorArmed = 1'b0;

  // Reference model state: refill in progress, next beat, its line, starvation run
  bit                mBurst = 1'b0;
  int                mBeat = 0;
  logic [LINE_W-1:0] mLine = '0;
  int                mStarve = 0;

  // Content the LS array returns for a quadword address
  function automatic logic [DATA_W-1:0] lsData(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = {18'h0, a} * 32'h9E3779B1;
    return {x ^ 32'hA5A5A5A5, x, ~x, {18'h0, a}};
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got %h want %h", name, cycle, act, exp);
    end
  endtask

  // Remove expected returns that have not yet come back
  function automatic void killReturns(input bit ifOnly);
    rdExp_t keep[$];
    foreach (expQ[i]) begin
      if (!(expQ[i].due > cycle && (!ifOnly || expQ[i].tag == 2'd2))) keep.push_back(expQ[i]);
    end
    expQ = keep;
  endfunction

  function automatic void pushRead(input logic [1:0] tag, input int beat, input logic [ADDR_W-1:0] addr);
    rdExp_t e;
    e.due  = cycle + LS_LAT;
    e.tag  = tag;
    e.beat = BEAT_W'(beat);
    e.addr = addr;
    expQ.push_back(e);
  endfunction

  // Apply the arbitration rules to the current inputs and check the issue side
  task automatic modelStep();
    logic [5:0]        eCtl;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eWdata;
    bit                ifWin;
    eCtl = '0; eAddr = '0; eWdata = '0; ifWin = 1'b0;
    if (reset) begin
      killReturns(1'b0);
      mBurst = 1'b0; mBeat = 0; mStarve = 0;
    end else begin
      if (if_flush) killReturns(1'b1);
      if (mBurst) begin
        eCtl  = 6'b000110;
        eAddr = {mLine, BEAT_W'(mBeat)};
        if (!if_flush) pushRead(2'd2, mBeat, eAddr);
        if (if_flush || mBeat == IF_BEATS - 1) mBurst = 1'b0;
        else mBeat++;
      end else begin
        ifWin = if_req && !if_flush && (mStarve == STARVE_MAX || (!dma_req && !lsu_req));
        if (ifWin) begin
          eCtl  = 6'b001110;
          eAddr = {if_line, {BEAT_W{1'b0}}};
          pushRead(2'd2, 0, eAddr);
          mLine = if_line; mBeat = 1; mBurst = 1'b1;
        end else if (dma_req) begin
          eCtl = {4'b1000, 1'b1, dma_we}; eAddr = dma_addr; eWdata = dma_wdata;
          if (!dma_we) pushRead(2'd0, 0, dma_addr);
        end else if (lsu_req) begin
          eCtl = {4'b0100, 1'b1, lsu_we}; eAddr = lsu_addr; eWdata = lsu_wdata;
          if (!lsu_we) pushRead(2'd1, 0, lsu_addr);
        end
      end
      if (if_req && !ifWin) mStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : STARVE_MAX;
      else mStarve = 0;
    end
    checkOutput("issue", 160'({dma_gnt, lsu_gnt, if_gnt, if_busy, ls_en, ls_we, ls_addr, ls_wdata}),
                160'({eCtl, eAddr, eWdata}));
  endtask

  // One clock of stimulus: drive inputs, then model and check the port
  task automatic applyStimulus(input logic rst, input logic dReq, input logic dWe, input logic [ADDR_W-1:0] dAddr,
                               input logic lReq, input logic lWe, input logic [ADDR_W-1:0] lAddr,
                               input logic iReq, input logic [LINE_W-1:0] iLine, input logic iFlush);
    @(posedge clk);
    #1;
    cycle++;
    reset = rst;
    dma_req = dReq; dma_we = dWe; dma_addr = dAddr;
    dma_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    lsu_req = lReq; lsu_we = lWe; lsu_addr = lAddr;
    lsu_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    if_req = iReq; if_line = iLine; if_flush = iFlush;
    if (lsSched.exists(cycle)) begin
      ls_rdata = lsData(lsSched[cycle]);
      lsSched.delete(cycle);
    end else begin
      ls_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    #2;
    modelStep();
    if (ls_en && !ls_we) lsSched[cycle + LS_LAT] = ls_addr;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: every cycle the return port must match the scoreboard head or be silent
  initial begin
    rdExp_t e;
    forever begin
      @(negedge clk);
      if (monitorArmed) begin
        if (expQ.size() > 0 && expQ[0].due == cycle) begin
          e = expQ.pop_front();
          checkOutput("rdReturn", 160'({rd_valid, if_done, rd_tag, rd_beat, rd_data}),
                      160'({1'b1, (e.tag == 2'd2 && e.beat == BEAT_W'(IF_BEATS - 1)), e.tag, e.beat, lsData(e.addr)}));
        end else begin
          checkOutput("rdIdle", 160'({rd_valid, if_done, rd_tag, rd_beat, rd_data}), 160'(0));
        end
      end
    end
  end

  initial begin
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    monitorArmed = 1'b1;
    idleCycles(2);

    // Lone refill of line 0x10: addresses 0x40..0x43, returns two cycles later
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h010, '0);
    idleCycles(6);

    // DMA and LSU hold off a waiting refill until it is starved
    for (int i = 0; i < 14; i++)
      applyStimulus('0, 1'b1, '0, 14'(16'h1000 + i), 1'b1, '0, 14'h0200, 1'b1, 12'h02A, '0);
    idleCycles(6);

    // LSU arrives mid-burst and waits for the first idle cycle
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h033, '0);
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, '0, '0, 1'b1, '0, 14'h0123, '0, '0, '0);
    idleCycles(4);

    // LSU read, then a refill flushed on its beat-1 cycle
    applyStimulus('0, '0, '0, '0, 1'b1, '0, 14'h0456, '0, '0, '0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h077, '0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1);
    idleCycles(6);

    // LSU write followed by DMA read
    applyStimulus('0, '0, '0, '0, 1'b1, 1'b1, 14'h0888, '0, '0, '0);
    applyStimulus('0, 1'b1, '0, 14'h0999, '0, '0, '0, '0, '0, '0);
    idleCycles(4);

    // Reset in the middle of a burst, then a fresh refill
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h0AB, '0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h0AB, '0);
    applyStimulus(1'b1, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    idleCycles(2);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b1, 12'h0CD, '0);
    idleCycles(6);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(255) == 0), ($urandom_range(9) < 5), 1'($urandom_range(1)), 14'($urandom()),
                    ($urandom_range(9) < 4), 1'($urandom_range(1)), 14'($urandom()),
                    ($urandom_range(9) < 5), 12'($urandom()), ($urandom_range(15) == 0));
    end
    idleCycles(LS_LAT + 3);
    checkOutput("drain", 160'(expQ.size()), 160'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
